// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE (arbitrate) -> EXEC (capture) -> RESP (hold until taken).
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_A,
    input  logic [XLEN-1:0]  req0_B,
    input  logic [4:0]       req0_shamt,
    input  logic [3:0]       req0_sel,
    input  logic             req0_bsel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_A,
    input  logic [XLEN-1:0]  req1_B,
    input  logic [4:0]       req1_shamt,
    input  logic [3:0]       req1_sel,
    input  logic             req1_bsel,

    output logic [XLEN-1:0]  alu_A,
    output logic [XLEN-1:0]  alu_B,
    output logic [4:0]       alu_shamt,
    output logic [3:0]       alu_sel,
    output logic             alu_B_sel,
    input  logic [XLEN-1:0]  alu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [XLEN-1:0]  opnd_a_q, opnd_a_d;
    logic [XLEN-1:0]  opnd_b_q, opnd_b_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [3:0]       sel_q, sel_d;
    logic             bsel_q, bsel_d;
    logic             id_q, id_d;
    logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic grant0, grant1, accept, handshake;

    // Contention goes to the requester named by ptr; a lone requester always wins.
    assign grant0    = req0_valid & (~req1_valid | ~ptr_q);
    assign grant1    = req1_valid & (~req0_valid |  ptr_q);
    assign accept    = (state_q == IDLE) & ~reset & (req0_valid | req1_valid);
    assign handshake = (state_q == RESP) & rsp_ready;

    assign req0_ready = (state_q == IDLE) & ~reset & grant0;
    assign req1_ready = (state_q == IDLE) & ~reset & grant1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d    = state_q;
        ptr_d      = ptr_q;
        opnd_a_d   = opnd_a_q;
        opnd_b_d   = opnd_b_q;
        shamt_d    = shamt_q;
        sel_d      = sel_q;
        bsel_d     = bsel_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opnd_a_d = grant1 ? req1_A     : req0_A;
                    opnd_b_d = grant1 ? req1_B     : req0_B;
                    shamt_d  = grant1 ? req1_shamt : req0_shamt;
                    sel_d    = grant1 ? req1_sel   : req0_sel;
                    bsel_d   = grant1 ? req1_bsel  : req0_bsel;
                    id_d     = grant1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                state_d    = RESP;
            end
            RESP: begin
                if (handshake) begin
                    ptr_d      = ~id_q;
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            opnd_a_q   <= '0;
            opnd_b_q   <= '0;
            shamt_q    <= '0;
            sel_q      <= '0;
            bsel_q     <= 1'b0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            opnd_a_q   <= opnd_a_d;
            opnd_b_q   <= opnd_b_d;
            shamt_q    <= shamt_d;
            sel_q      <= sel_d;
            bsel_q     <= bsel_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    assign alu_A     = opnd_a_q;
    assign alu_B     = opnd_b_q;
    assign alu_shamt = shamt_q;
    assign alu_sel   = sel_q;
    assign alu_B_sel = bsel_q;

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts grants and results,
// a negedge monitor compares every cycle; a CNT_W=2 twin exercises counter wrap.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_sel, req1_sel;
    logic        req0_bsel, req1_bsel;
    logic [31:0] alu_A, alu_B, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_sel;
    logic        alu_B_sel;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;
    logic [15:0] op_count;

    logic        w_req0_ready, w_req1_ready, w_alu_B_sel, w_rsp_valid, w_rsp_id, w_busy;
    logic [31:0] w_alu_A, w_alu_B, w_alu_out, w_rsp_data;
    logic [4:0]  w_alu_shamt;
    logic [3:0]  w_alu_sel;
    logic [1:0]  w_op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour, straight from the opcode table.
    function automatic logic [31:0] alu_fn(input logic [3:0] sel, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out   = alu_fn(alu_sel, alu_A, alu_B, alu_shamt);
    assign w_alu_out = alu_fn(w_alu_sel, w_alu_A, w_alu_B, w_alu_shamt);

    alu_arbiter #(.XLEN(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_shamt(req0_shamt), .req0_sel(req0_sel), .req0_bsel(req0_bsel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_shamt(req1_shamt), .req1_sel(req1_sel), .req1_bsel(req1_bsel),
        .alu_A(alu_A), .alu_B(alu_B), .alu_shamt(alu_shamt), .alu_sel(alu_sel),
        .alu_B_sel(alu_B_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.XLEN(32), .CNT_W(2)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_shamt(req0_shamt), .req0_sel(req0_sel), .req0_bsel(req0_bsel),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_shamt(req1_shamt), .req1_sel(req1_sel), .req1_bsel(req1_bsel),
        .alu_A(w_alu_A), .alu_B(w_alu_B), .alu_shamt(w_alu_shamt), .alu_sel(w_alu_sel),
        .alu_B_sel(w_alu_B_sel), .alu_out(w_alu_out),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id), .rsp_data(w_rsp_data),
        .busy(w_busy), .op_count(w_op_count)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one job in flight, three-cycle life, ptr flips on hand-off.
    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        bsel;
    } exp_t;

    exp_t q[$];
    int   m_phase = 0;   // 0 waiting for work, 1 computing, 2 result offered
    logic m_ptr   = 1'b0;
    int   m_cnt   = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_ptr   = 1'b0;
            m_cnt   = 0;
            q.delete();
        end else if (m_phase == 0) begin
            if (req0_valid || req1_valid) begin
                exp_t e;
                e.id = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                if (e.id) begin
                    e.data = alu_fn(req1_sel, req1_A, req1_B, req1_shamt);
                    e.bsel = req1_bsel;
                end else begin
                    e.data = alu_fn(req0_sel, req0_A, req0_B, req0_shamt);
                    e.bsel = req0_bsel;
                end
                q.push_back(e);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rsp_ready) begin
            m_ptr = !q[0].id;
            void'(q.pop_front());
            m_cnt++;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic e0, e1;
            e0 = !reset && m_phase == 0 && req0_valid && (!req1_valid || !m_ptr);
            e1 = !reset && m_phase == 0 && req1_valid && (!req0_valid ||  m_ptr);
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            check("rsp_valid", rsp_valid, m_phase == 2);
            check("busy", busy, m_phase != 0);
            check("op_count", op_count, m_cnt % 65536);
            check("op_count_wrap", w_op_count, m_cnt % 4);
            if (m_phase == 2 && q.size() > 0) begin
                check("rsp_id", rsp_id, q[0].id);
                check("rsp_data", rsp_data, q[0].data);
            end
            if (m_phase == 1 && q.size() > 0)
                check("alu_B_sel", alu_B_sel, q[0].bsel);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit n, input logic v, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        if (n) begin
            req1_valid = v; req1_sel = sel; req1_A = a; req1_B = b; req1_shamt = sh; req1_bsel = 1'b0;
        end else begin
            req0_valid = v; req0_sel = sel; req0_A = a; req0_B = b; req0_shamt = sh; req0_bsel = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        reset = 1'b0;
        mon_en = 1'b1;
        check("reset_alu_A", alu_A, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", rsp_id, 1'b0);
        check("reset_op_count", op_count, 16'd0);

        // Single op: 5 + 3
        set_req(0, 1'b1, 4'd0, 32'h5, 32'h3, 5'd0);
        step();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        check("single_valid", rsp_valid, 1'b1);
        check("single_id", rsp_id, 1'b0);
        check("single_data", rsp_data, 32'h8);
        step();
        check("single_count", op_count, 16'd1);

        // Contention straight after reset
        do_reset();
        set_req(0, 1'b1, 4'd1, 32'h10, 32'h01, 5'd0);
        set_req(1, 1'b1, 4'd2, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0);
        step(); step();
        check("cont0_id", rsp_id, 1'b0);
        check("cont0_data", rsp_data, 32'h0000000F);
        step(); step(); step();
        check("cont1_id", rsp_id, 1'b1);
        check("cont1_data", rsp_data, 32'hF00FF00F);
        step();

        // Round-robin with both held valid, plus wrap on the CNT_W=2 twin
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(); step();
            check("rr_id", rsp_id, k[0]);
            step();
        end
        check("rr_count", op_count, 16'd4);
        check("wrap_count", w_op_count, 2'd0);

        // Backpressure for 5 cycles in RESP
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        set_req(0, 1'b1, 4'd3, 32'h1234_0000, 32'h0000_5678, 5'd0);
        rsp_ready = 1'b0;
        step();
        set_req(1, 1'b1, 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_data", rsp_data, 32'h1234_5678);
            check("bp_ready", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        step();
        step();
        check("bp_next_winner", alu_sel, 4'd4);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step(); step();

        // Reset while req1's sra is in EXEC
        set_req(1, 1'b1, 4'd7, 32'h8000_0000, 32'd0, 5'd4);
        step();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        check("midrst_busy", busy, 1'b1);
        do_reset();
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_count", op_count, 16'd0);
        check("midrst_alu_A", alu_A, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("midrst_no_rsp", rsp_valid, 1'b0);
        end

        // Randomized traffic checked by the monitor against the model
        for (int c = 0; c < 1500; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_A = $urandom(); req0_B = $urandom(); req0_shamt = 5'($urandom());
            req1_A = $urandom(); req1_B = $urandom(); req1_shamt = 5'($urandom());
            req0_sel = 4'($urandom_range(0, 11)); req1_sel = 4'($urandom_range(0, 11));
            req0_bsel = 1'($urandom()); req1_bsel = 1'($urandom());
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
